// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_controller
// Brief   : Multicycle FSM control unit with ready/valid fetch, JMPZ, HALT and illegal-opcode trap.
// Revision: 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int WIDTH     = 16,
    parameter int D_ADDR_W  = 8,
    parameter int R_ADDR_W  = 4,
    parameter int I_ADDR_W  = 7,
    localparam int IR_W     = 4 + R_ADDR_W + D_ADDR_W
) (
    input  logic                Clk,
    input  logic                Reset,
    output logic                I_req,
    output logic [I_ADDR_W-1:0] I_addr,
    input  logic                I_valid,
    input  logic [IR_W-1:0]     I_data,
    output logic [D_ADDR_W-1:0] D_addr,
    output logic                D_wr,
    output logic                RF_s,
    output logic                RF_W_en,
    output logic [R_ADDR_W-1:0] RF_W_addr,
    output logic [R_ADDR_W-1:0] RF_A_addr,
    output logic [R_ADDR_W-1:0] RF_B_addr,
    output logic [3:0]          ALU_sel,
    input  logic                RF_A_zero,
    output logic [IR_W-1:0]     IR_Out,
    output logic [I_ADDR_W-1:0] PC_Out,
    output logic [3:0]          State,
    output logic [3:0]          NextState,
    output logic                Halted,
    output logic                Illegal
);

    if (WIDTH < 1 || D_ADDR_W < 2 * R_ADDR_W || I_ADDR_W > D_ADDR_W) begin : g_bad_params
        $error("multicycle_controller: inconsistent address-width parameters");
    end

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ALU    = 4'd7,
        S_JMPZ   = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] c_op_noop  = 4'd0;
    localparam logic [3:0] c_op_store = 4'd1;
    localparam logic [3:0] c_op_load  = 4'd2;
    localparam logic [3:0] c_op_add   = 4'd3;
    localparam logic [3:0] c_op_sub   = 4'd4;
    localparam logic [3:0] c_op_jmpz  = 4'd5;
    localparam logic [3:0] c_op_halt  = 4'd6;
    localparam logic [I_ADDR_W-1:0] c_pc_one = {{(I_ADDR_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next;
    logic [IR_W-1:0]     r_ir;
    logic [I_ADDR_W-1:0] r_pc;
    logic                r_illegal;

    logic [3:0]          w_op;
    logic [R_ADDR_W-1:0] w_rd;
    logic [R_ADDR_W-1:0] w_ra;
    logic [R_ADDR_W-1:0] w_rb;
    logic [D_ADDR_W-1:0] w_addr;

    assign w_op   = r_ir[IR_W-1 -: 4];
    assign w_rd   = r_ir[D_ADDR_W +: R_ADDR_W];
    assign w_addr = r_ir[D_ADDR_W-1:0];
    assign w_ra   = r_ir[2*R_ADDR_W-1:R_ADDR_W];
    assign w_rb   = r_ir[R_ADDR_W-1:0];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_INIT;
            r_ir      <= '0;
            r_pc      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH: begin
                    if (I_valid) begin
                        r_ir <= I_data;
                        r_pc <= r_pc + c_pc_one;
                    end
                end
                S_DECODE: begin
                    if (w_op > c_op_halt) begin
                        r_illegal <= 1'b1;
                    end
                end
                S_JMPZ: begin
                    if (RF_A_zero) begin
                        r_pc <= w_addr[I_ADDR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = I_valid ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_op)
                    c_op_noop:  w_next = S_NOOP;
                    c_op_store: w_next = S_STORE;
                    c_op_load:  w_next = S_LOAD_A;
                    c_op_add:   w_next = S_ALU;
                    c_op_sub:   w_next = S_ALU;
                    c_op_jmpz:  w_next = S_JMPZ;
                    c_op_halt:  w_next = S_HALT;
                    default:    w_next = S_NOOP;
                endcase
            end
            S_NOOP:   w_next = S_FETCH;
            S_LOAD_A: w_next = S_LOAD_B;
            S_LOAD_B: w_next = S_FETCH;
            S_STORE:  w_next = S_FETCH;
            S_ALU:    w_next = S_FETCH;
            S_JMPZ:   w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_INIT;
        endcase
    end

    // Moore outputs: decoded only from the current state and the IR.
    always_comb begin
        I_req     = 1'b0;
        D_addr    = '0;
        D_wr      = 1'b0;
        RF_s      = 1'b0;
        RF_W_en   = 1'b0;
        RF_W_addr = '0;
        RF_A_addr = '0;
        RF_B_addr = '0;
        ALU_sel   = 4'd0;
        case (r_state)
            S_FETCH:  I_req = 1'b1;
            S_DECODE: begin
                RF_A_addr = w_ra;
                RF_B_addr = w_rb;
            end
            S_LOAD_A: begin
                D_addr = w_addr;
                RF_s   = 1'b1;
            end
            S_LOAD_B: begin
                D_addr    = w_addr;
                RF_s      = 1'b1;
                RF_W_en   = 1'b1;
                RF_W_addr = w_rd;
            end
            S_STORE: begin
                D_addr    = w_addr;
                RF_A_addr = w_rd;
                D_wr      = 1'b1;
            end
            S_ALU: begin
                RF_A_addr = w_ra;
                RF_B_addr = w_rb;
                ALU_sel   = (w_op == c_op_add) ? 4'd1 : 4'd2;
                RF_W_en   = 1'b1;
                RF_W_addr = w_rd;
            end
            S_JMPZ:   RF_A_addr = w_rd;
            default: ;
        endcase
    end

    assign I_addr    = r_pc;
    assign IR_Out    = r_ir;
    assign PC_Out    = r_pc;
    assign State     = r_state;
    assign NextState = w_next;
    assign Halted    = (r_state == S_HALT);
    assign Illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_controller
// Brief   : Directed scoreboard bench for multicycle_controller.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        I_req;
    logic [6:0]  I_addr;
    logic        I_valid = 1'b0;
    logic [15:0] I_data = 16'h0;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic        RF_W_en;
    logic [3:0]  RF_W_addr;
    logic [3:0]  RF_A_addr;
    logic [3:0]  RF_B_addr;
    logic [3:0]  ALU_sel;
    logic        RF_A_zero = 1'b0;
    logic [15:0] IR_Out;
    logic [6:0]  PC_Out;
    logic [3:0]  State;
    logic [3:0]  NextState;
    logic        Halted;
    logic        Illegal;

    multicycle_controller dut (
        .Clk(Clk), .Reset(Reset), .I_req(I_req), .I_addr(I_addr), .I_valid(I_valid),
        .I_data(I_data), .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s), .RF_W_en(RF_W_en),
        .RF_W_addr(RF_W_addr), .RF_A_addr(RF_A_addr), .RF_B_addr(RF_B_addr),
        .ALU_sel(ALU_sel), .RF_A_zero(RF_A_zero), .IR_Out(IR_Out), .PC_Out(PC_Out),
        .State(State), .NextState(NextState), .Halted(Halted), .Illegal(Illegal)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] st;
        logic [7:0] da;
        logic       dwr;
        logic       rfs;
        logic       wen;
        logic [3:0] wa;
        logic [3:0] aa;
        logic [3:0] ba;
        logic [3:0] alu;
        logic       ireq;
    } out_t;

    out_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [6:0]  exp_pc = 7'd0;
    logic [15:0] exp_ir = 16'h0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic out_t mk(input logic [3:0] st, input logic [7:0] da, input logic dwr,
                                input logic rfs, input logic wen, input logic [3:0] wa,
                                input logic [3:0] aa, input logic [3:0] ba, input logic [3:0] alu);
        out_t r;
        r.st = st; r.da = da; r.dwr = dwr; r.rfs = rfs; r.wen = wen;
        r.wa = wa; r.aa = aa; r.ba = ba; r.alu = alu; r.ireq = 1'b0;
        return r;
    endfunction

    function automatic out_t observed();
        out_t r;
        r.st = State; r.da = D_addr; r.dwr = D_wr; r.rfs = RF_s; r.wen = RF_W_en;
        r.wa = RF_W_addr; r.aa = RF_A_addr; r.ba = RF_B_addr; r.alu = ALU_sel; r.ireq = I_req;
        return r;
    endfunction

    // Expected per-cycle outputs of one instruction, from DECODE to its last execute state.
    task automatic push_exec(input logic [15:0] instr);
        logic [3:0] op, rd, ra, rb;
        logic [7:0] ad;
        op = instr[15:12]; rd = instr[11:8]; ad = instr[7:0]; ra = instr[7:4]; rb = instr[3:0];
        sb.push_back(mk(4'd2, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, ra, rb, 4'd0));
        case (op)
            4'd1: sb.push_back(mk(4'd6, ad, 1'b1, 1'b0, 1'b0, 4'h0, rd, 4'h0, 4'd0));
            4'd2: begin
                sb.push_back(mk(4'd4, ad, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'd0));
                sb.push_back(mk(4'd5, ad, 1'b0, 1'b1, 1'b1, rd, 4'h0, 4'h0, 4'd0));
            end
            4'd3: sb.push_back(mk(4'd7, 8'h0, 1'b0, 1'b0, 1'b1, rd, ra, rb, 4'd1));
            4'd4: sb.push_back(mk(4'd7, 8'h0, 1'b0, 1'b0, 1'b1, rd, ra, rb, 4'd2));
            4'd5: sb.push_back(mk(4'd8, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, rd, 4'h0, 4'd0));
            4'd6: sb.push_back(mk(4'd9, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'd0));
            default: sb.push_back(mk(4'd3, 8'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'd0));
        endcase
    endtask

    task automatic run_exec(input string tag);
        out_t e;
        int   n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("%s exec%0d", tag, n), observed(), e);
            n++;
            tick();
        end
    endtask

    // Serve one fetch with the given number of wait cycles, then execute the instruction.
    task automatic fetch_exec(input logic [15:0] instr, input int waits, input string tag);
        check({tag, " fetch state"}, State, 4'd1);
        check({tag, " I_req"}, I_req, 1'b1);
        check({tag, " I_addr"}, I_addr, exp_pc);
        for (int i = 0; i < waits; i++) begin
            I_valid = 1'b0;
            I_data  = 16'hFFFF;
            tick();
            check($sformatf("%s wait%0d state", tag, i), State, 4'd1);
            check($sformatf("%s wait%0d pc", tag, i), PC_Out, exp_pc);
            check($sformatf("%s wait%0d ir", tag, i), IR_Out, exp_ir);
        end
        I_valid = 1'b1;
        I_data  = instr;
        tick();
        I_valid = 1'b0;
        exp_pc  = exp_pc + 7'd1;
        exp_ir  = instr;
        check({tag, " ir load"}, IR_Out, exp_ir);
        check({tag, " pc inc"}, PC_Out, exp_pc);
        push_exec(instr);
        run_exec(tag);
    endtask

    initial begin
        #2 Reset = 1'b1;
        #1;
        check("reset state", State, 4'd0);
        check("reset pc", PC_Out, 7'd0);
        check("reset ir", IR_Out, 16'h0);
        check("reset i_req", I_req, 1'b0);
        check("reset illegal", Illegal, 1'b0);
        check("reset halted", Halted, 1'b0);
        tick();
        Reset = 1'b0;
        check("init hold", State, 4'd0);
        tick();
        check("init to fetch", State, 4'd1);

        fetch_exec(16'h2110, 3, "load r1");
        fetch_exec(16'h2211, 0, "load r2");
        fetch_exec(16'h3312, 1, "add r3");
        fetch_exec(16'h1312, 0, "store r3");
        fetch_exec(16'h4512, 0, "sub r5");
        check("program pc", PC_Out, 7'd5);

        check("midfetch pre state", State, 4'd1);
        check("midfetch pre i_req", I_req, 1'b1);
        #3 Reset = 1'b1;
        #1;
        check("midfetch i_req", I_req, 1'b0);
        check("midfetch state", State, 4'd0);
        check("midfetch pc", PC_Out, 7'd0);
        check("midfetch ir", IR_Out, 16'h0);
        tick();
        Reset  = 1'b0;
        exp_pc = 7'd0;
        exp_ir = 16'h0;
        tick();
        check("restart fetch", State, 4'd1);

        RF_A_zero = 1'b1;
        fetch_exec(16'h5420, 0, "jmpz taken");
        exp_pc = 7'h20;
        check("jmpz taken pc", PC_Out, exp_pc);
        RF_A_zero = 1'b0;
        fetch_exec(16'h5420, 2, "jmpz not taken");
        check("jmpz not taken pc", PC_Out, 7'h21);
        RF_A_zero = 1'b1;
        fetch_exec(16'h547F, 0, "jmpz to 127");
        exp_pc = 7'h7F;
        RF_A_zero = 1'b0;
        check("pc at 127", PC_Out, 7'h7F);
        fetch_exec(16'h0000, 0, "noop wrap");
        check("pc wrapped", PC_Out, 7'h00);

        check("illegal clear", Illegal, 1'b0);
        fetch_exec(16'hF000, 0, "illegal op");
        check("illegal set", Illegal, 1'b1);
        fetch_exec(16'h0000, 0, "noop after illegal");
        check("illegal sticky", Illegal, 1'b1);
        fetch_exec(16'h6000, 0, "halt");
        I_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("halt%0d i_req", i), I_req, 1'b0);
            check($sformatf("halt%0d state", i), State, 4'd9);
            check($sformatf("halt%0d halted", i), Halted, 1'b1);
            check($sformatf("halt%0d illegal", i), Illegal, 1'b1);
            tick();
        end
        I_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
